// File: rtl/lfsr_stream_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lfsr_stream_gen: Fibonacci XNOR LFSR pattern stream with valid/ready,     |
// | period-wrap pulse and lock-up flag. Option: LFSR_LOCKUP_RECOVER_EN.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module lfsr_stream_gen #(
   parameter int               WIDTH = 4,
   parameter logic [WIDTH-1:0] TAPS  = 4'b1100,
   parameter logic [WIDTH-1:0] SEED  = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] seed_in,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out,
   output logic             wrap,
   output logic             locked
);

   // Last count value of a full period, 2^WIDTH-2
   localparam logic [WIDTH-1:0] c_CNT_LAST = {{(WIDTH-1){1'b1}}, 1'b0};

   logic [WIDTH-1:0] r_s;
   logic [WIDTH-1:0] r_cnt;
   logic             r_valid;
   logic             r_wrap;
   logic             w_fb;
   logic [WIDTH-1:0] w_next;
   logic             w_adv;

   assign w_fb   = ~^(r_s & TAPS);
   assign w_next = {r_s[WIDTH-2:0], w_fb};
   assign w_adv  = r_valid & out_ready & en & ~load;

   assign out       = r_s;
   assign out_valid = r_valid;
   assign wrap      = r_wrap;
   assign locked    = &r_s;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_s     <= SEED;
         r_cnt   <= '0;
         r_valid <= 1'b0;
         r_wrap  <= 1'b0;
      end else if (load) begin
         r_s     <= seed_in;
         r_cnt   <= '0;
         r_valid <= 1'b0;
         r_wrap  <= 1'b0;
      end else begin
         r_valid <= en;
         r_wrap  <= 1'b0;
         if (w_adv) begin
`ifdef LFSR_LOCKUP_RECOVER_EN
            if (locked) begin
               r_s   <= SEED;
               r_cnt <= '0;
            end else begin
               r_s <= w_next;
               if (r_cnt == c_CNT_LAST) begin
                  r_cnt  <= '0;
                  r_wrap <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
`else
            // All-ones feeds back a one, so the lock-up state persists on its own
            r_s <= w_next;
            if (r_cnt == c_CNT_LAST) begin
               r_cnt  <= '0;
               r_wrap <= 1'b1;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
`endif
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_lfsr_stream_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_lfsr_stream_gen: scoreboard bench for lfsr_stream_gen (WIDTH=4).       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_lfsr_stream_gen;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic       load;
   logic [3:0] seed_in;
   logic       out_ready;
   logic       out_valid;
   logic [3:0] out;
   logic       wrap;
   logic       locked;

   int         n_chk  = 0;
   int         n_fail = 0;
   int         n_acc  = 0;
   int         n_wrap = 0;
   logic [3:0] exp_q[$];

   lfsr_stream_gen #(.WIDTH(4), .TAPS(4'b1100), .SEED(4'h0)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .load      (load),
      .seed_in   (seed_in),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out       (out),
      .wrap      (wrap),
      .locked    (locked)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [63:0] words, input int n);
      for (int i = n - 1; i >= 0; i--) exp_q.push_back(words[i*4 +: 4]);
   endtask

   task automatic run_accepts(input int n);
      int target;
      int budget;
      target = n_acc + n;
      budget = 0;
      while (n_acc < target && budget < 200) begin
         cyc();
         budget++;
      end
      check("accept_timeout", n_acc, target);
   endtask

   // Scoreboard: the word on out is consumed at the next rising edge
   always @(negedge clk) begin
      if (rst && out_valid && out_ready && en && !load) begin
         if (exp_q.size() == 0) begin
            check("sb_underflow", exp_q.size(), 1);
         end else begin
            check("sb_word", out, exp_q.pop_front());
         end
         n_acc++;
      end
      if (wrap) n_wrap++;
   end

   initial begin
      int w0;
      rst = 1'b0; en = 1'b0; load = 1'b0; seed_in = 4'h0; out_ready = 1'b1;
      cyc(); cyc();
      check("rst_out", out, 4'h0);
      check("rst_valid", out_valid, 1'b0);
      check("rst_wrap", wrap, 1'b0);
      check("rst_locked", locked, 1'b0);
      rst = 1'b1;
      cyc();
      check("idle_valid", out_valid, 1'b0);

      // Full period from reset
      en = 1'b1;
      push(64'h0137EDB6C925A480, 16);
      cyc();
      check("en_valid_rise", out_valid, 1'b1);
      check("first_word", out, 4'h0);
      run_accepts(15);
      check("period_wrap_cnt", n_wrap, 0);
      check("period_wrap", wrap, 1'b1);
      run_accepts(1);
      check("period_wrap_once", n_wrap, 1);
      check("period_next", out, 4'h1);

      // Backpressure at 7
      push(64'h137, 3);
      run_accepts(2);
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cyc();
         check("bp_hold", out, 4'h7);
         check("bp_valid", out_valid, 1'b1);
      end
      out_ready = 1'b1;
      push(64'hE, 1);
      run_accepts(2);
      check("bp_after", out, 4'hD);

      // Seed load while streaming
      load = 1'b1; seed_in = 4'h9;
      cyc();
      check("load_out", out, 4'h9);
      check("load_valid", out_valid, 1'b0);
      load = 1'b0;
      cyc();
      check("load_valid_rise", out_valid, 1'b1);
      w0 = n_wrap;
      push(64'h925A4801_37EDB6C, 15);
      run_accepts(14);
      check("load_no_early_wrap", wrap, 1'b0);
      run_accepts(1);
      check("load_wrap_cnt", n_wrap, w0);
      check("load_wrap", wrap, 1'b1);
      check("load_period", out, 4'h9);

      // Asynchronous reset at B
      push(64'h925A480137ED, 12);
      run_accepts(12);
      check("pre_rst_out", out, 4'hB);
      #2;
      rst = 1'b0;
      #1;
      check("arst_out", out, 4'h0);
      check("arst_valid", out_valid, 1'b0);
      check("arst_wrap", wrap, 1'b0);
      cyc();
      rst = 1'b1;
      cyc();
      check("rst_rel_valid", out_valid, 1'b1);
      push(64'h0137EDB, 7);
      run_accepts(7);
      check("restart_out", out, 4'h6);

      // Enable drop at 6
      en = 1'b0;
      cyc();
      check("en_drop_valid", out_valid, 1'b0);
      check("en_drop_out", out, 4'h6);
      cyc(); cyc();
      check("en_hold_out", out, 4'h6);
      en = 1'b1;
      cyc();
      check("en_rise_valid", out_valid, 1'b1);
      push(64'h6C, 2);
      run_accepts(2);
      check("en_resume", out, 4'h9);

      // Lock-up state
      load = 1'b1; seed_in = 4'hF;
      cyc();
      check("lock_out", out, 4'hF);
      check("lock_flag", locked, 1'b1);
      load = 1'b0;
`ifdef LFSR_LOCKUP_RECOVER_EN
      push(64'hF, 1);
      run_accepts(1);
      check("recover_out", out, 4'h0);
      check("recover_flag", locked, 1'b0);
`else
      push(64'hFFFF_FFFF_FFFF_FFFF, 16);
      push(64'hFFFF, 4);
      run_accepts(20);
      check("stuck_out", out, 4'hF);
      check("stuck_flag", locked, 1'b1);
`endif
      en = 1'b0;
      cyc();
      check("sb_drained", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
